// File: rtl/opcodes_pkg.sv
// Shared type definitions used by the program-memory arbiter and its neighbours.
package opcodes;

  typedef enum logic [1:0] {ArbIdle, ArbAccess, ArbResp} arb_state_t;
  typedef enum logic {OwnCpu, OwnLd} arb_owner_t;

endpackage

// File: rtl/burst_limiter.sv
// Saturating count of back-to-back loader grants taken while the CPU was waiting.
module burst_limiter #(
  parameter int MAX_LD_BURST = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  input  logic sat_en,
  output logic at_limit
);

  localparam int CntW = $clog2(MAX_LD_BURST + 1);
  localparam logic [CntW-1:0] Limit = CntW'(MAX_LD_BURST);

  logic [CntW-1:0] burstCnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      burstCnt <= '0;
    end else if (inc && sat_en && (burstCnt != Limit)) begin
      burstCnt <= burstCnt + 1'b1;
    end
  end

  assign at_limit = (burstCnt == Limit);

endmodule

// File: rtl/pmem_arbiter.sv
// Serialises CPU fetches and loader reads/writes onto the single-port program memory.
module pmem_arbiter
  import opcodes::*;
#(
  parameter int AW           = 5,
  parameter int DW           = 16,
  parameter int MAX_LD_BURST = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state, nextState;
  arb_owner_t ownerQ;
  logic [AW-1:0] addrQ;
  logic [DW-1:0] wdataQ;
  logic weQ;

  logic isIdle, isAccess, isResp;
  logic atLimit, grantLd, grantCpu;

  assign isIdle   = (state == ArbIdle);
  assign isAccess = (state == ArbAccess);
  assign isResp   = (state == ArbResp);

  // Lock hands the port to the loader outright; otherwise the loader wins ties until the burst limit.
  assign grantLd  = isIdle && ld_req && (ld_lock || !cpu_req || !atLimit);
  assign grantCpu = isIdle && cpu_req && !ld_lock && (!ld_req || atLimit);

  burst_limiter #(.MAX_LD_BURST(MAX_LD_BURST)) uLimiter (
    .Clock   (Clock),
    .Reset   (Reset),
    .inc     (grantLd && cpu_req),
    .clr     (grantCpu || (isIdle && !cpu_req)),
    .sat_en  (!ld_lock),
    .at_limit(atLimit)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ArbIdle;
      ownerQ <= OwnCpu;
      addrQ  <= '0;
      wdataQ <= '0;
      weQ    <= 1'b0;
    end else begin
      state <= nextState;
      if (grantLd) begin
        ownerQ <= OwnLd;
        addrQ  <= ld_addr;
        wdataQ <= ld_wdata;
        weQ    <= ld_we;
      end else if (grantCpu) begin
        ownerQ <= OwnCpu;
        addrQ  <= cpu_addr;
        wdataQ <= '0;
        weQ    <= 1'b0;
      end
    end
  end

  // NOTE: assigning a default before the case keeps this block free of inferred latches.
  always_comb begin
    nextState = state;
    unique case (state)
      ArbIdle:   if (grantLd || grantCpu) nextState = ArbAccess;
      ArbAccess: nextState = ArbResp;
      ArbResp:   nextState = ArbIdle;
      default:   nextState = ArbIdle;
    endcase
  end

  // Port and response outputs decode straight from state, so a reset edge never hides them early.
  assign mem_en    = isAccess;
  assign mem_we    = isAccess && (ownerQ == OwnLd) && weQ;
  assign mem_addr  = isAccess ? addrQ : '0;
  assign mem_wdata = isAccess ? wdataQ : '0;

  assign cpu_ack   = isResp && (ownerQ == OwnCpu);
  assign ld_ack    = isResp && (ownerQ == OwnLd);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign ld_rdata  = ld_ack ? mem_rdata : '0;
  assign cpu_hold  = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a behavioural synchronous program memory.
module tb_pmem_arbiter;
  import opcodes::*;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          cpu_req, ld_req, ld_we, ld_lock;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          cpu_ack, cpu_hold, ld_ack;
  logic [DW-1:0] cpu_rdata, ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  pmem_arbiter #(.AW(AW), .DW(DW), .MAX_LD_BURST(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Registered-output RAM; contents are preloaded, never reset.
  always @(posedge Clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  bit expCpu [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int cpuAcks, ldAcks, holdLow;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= '0;
    mem[3] <= 16'hA5C3;
    mem_rdata <= '0;
    Reset = 1'b1;
    cpu_req = 0; ld_req = 0; ld_we = 0; ld_lock = 0;
    cpu_addr = '0; ld_addr = '0; ld_wdata = '0;

    // Reset state
    cyc(); cyc();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_ld_ack", 32'(ld_ack), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_hold_lo", 32'(cpu_hold), 0);
    cpu_req = 1; #1;
    check("rst_hold_hi", 32'(cpu_hold), 1);
    cpu_req = 0;
    Reset = 1'b0;
    cyc();

    // CPU fetch only
    cpu_req = 1; cpu_addr = 5'h03; #1;
    check("f_hold_n", 32'(cpu_hold), 1);
    check("f_en_n", 32'(mem_en), 0);
    cyc();
    check("f_en_n1", 32'(mem_en), 1);
    check("f_addr_n1", 32'(mem_addr), 32'h03);
    check("f_we_n1", 32'(mem_we), 0);
    check("f_hold_n1", 32'(cpu_hold), 1);
    check("f_ack_n1", 32'(cpu_ack), 0);
    cyc();
    check("f_ack_n2", 32'(cpu_ack), 1);
    check("f_rdata_n2", 32'(cpu_rdata), 32'hA5C3);
    check("f_hold_n2", 32'(cpu_hold), 0);
    check("f_ldack_n2", 32'(ld_ack), 0);
    cpu_req = 0;
    cyc();
    check("f_ack_n3", 32'(cpu_ack), 0);
    check("f_rdata_n3", 32'(cpu_rdata), 0);

    // Loader write then read-back at the top address
    ld_req = 1; ld_we = 1; ld_addr = 5'h1F; ld_wdata = 16'h1234;
    cyc();
    check("lw_en", 32'(mem_en), 1);
    check("lw_we", 32'(mem_we), 1);
    check("lw_addr", 32'(mem_addr), 32'h1F);
    check("lw_wdata", 32'(mem_wdata), 32'h1234);
    cyc();
    check("lw_ack", 32'(ld_ack), 1);
    ld_req = 0;
    cyc();
    ld_req = 1; ld_we = 0; ld_wdata = 16'h0000;
    cyc();
    check("lr_we", 32'(mem_we), 0);
    cyc();
    check("lr_ack", 32'(ld_ack), 1);
    check("lr_rdata", 32'(ld_rdata), 32'h1234);
    ld_req = 0;
    cyc();
    check("lr_rdata_idle", 32'(ld_rdata), 0);

    // Fairness: both held, expect L,L,L,L,C,L,L,L,L,C
    cpu_req = 1; cpu_addr = 5'h03;
    ld_req = 1; ld_we = 0; ld_addr = 5'h1F;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (k % 3 == 2) begin
        check($sformatf("bu_cpu_ack_s%0d", k / 3), 32'(cpu_ack), 32'(expCpu[k / 3]));
        check($sformatf("bu_ld_ack_s%0d", k / 3), 32'(ld_ack), 32'(!expCpu[k / 3]));
        if (expCpu[k / 3]) check($sformatf("bu_rdata_s%0d", k / 3), 32'(cpu_rdata), 32'hA5C3);
      end
      cyc();
    end
    cpu_req = 0; ld_req = 0;
    cyc();

    // Lock: CPU starved while locked, granted right after release
    cpu_req = 1; ld_req = 1; ld_lock = 1;
    cpuAcks = 0; ldAcks = 0; holdLow = 0;
    for (int k = 0; k < 21; k++) begin
      #1;
      if (cpu_ack) cpuAcks++;
      if (ld_ack) ldAcks++;
      if (!cpu_hold) holdLow++;
      if (k == 20) begin
        ld_req = 0; ld_lock = 0;
      end
      cyc();
    end
    check("lk_cpu_acks", 32'(cpuAcks), 0);
    check("lk_ld_acks", 32'(ldAcks), 7);
    check("lk_hold_low", 32'(holdLow), 0);
    check("lk_idle_en", 32'(mem_en), 0);
    cyc();
    check("lk_rel_en", 32'(mem_en), 1);
    check("lk_rel_addr", 32'(mem_addr), 32'h03);
    cyc();
    check("lk_rel_ack", 32'(cpu_ack), 1);
    cpu_req = 0;
    cyc();

    // Reset during ACCESS of a loader write; the write still lands
    ld_req = 1; ld_we = 1; ld_addr = 5'h07; ld_wdata = 16'hBEEF;
    cyc();
    Reset = 1; ld_req = 0; #1;
    check("ra_en", 32'(mem_en), 1);
    check("ra_we", 32'(mem_we), 1);
    cyc();
    check("ra_no_ack", 32'(ld_ack), 0);
    check("ra_state", 32'(dut.state), 32'(ArbIdle));
    Reset = 0;
    ld_req = 1; ld_we = 0; ld_wdata = '0;
    cyc();
    cyc();
    check("ra_rd_ack", 32'(ld_ack), 1);
    check("ra_rd_data", 32'(ld_rdata), 32'hBEEF);
    ld_req = 0;
    cyc();

    // CPU withdraws in ACCESS after a loader grant bumped the burst count
    cpu_req = 1; ld_req = 1; ld_we = 0; ld_addr = 5'h1F;
    cyc();
    cyc();
    ld_req = 0;
    cyc();
    check("wd_cnt_one", 32'(dut.uLimiter.burstCnt), 1);
    cyc();
    check("wd_en", 32'(mem_en), 1);
    cpu_req = 0; #1;
    check("wd_hold", 32'(cpu_hold), 0);
    cyc();
    check("wd_ack", 32'(cpu_ack), 1);
    check("wd_cnt_clr", 32'(dut.uLimiter.burstCnt), 0);
    cyc();
    check("wd_idle", 32'(dut.state), 32'(ArbIdle));
    check("wd_ack_gone", 32'(cpu_ack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates the single-port synchronous program memory between two requesters: the CPU instruction fetch, driven from the `control` Fetch phase, and the program loader, a switch/serial download port that writes or reads back words. Accesses are serialised through a three-phase Idle/Access/Respond sequencer. A fairness counter stops a streaming loader from starving the CPU. A lock input gives the loader exclusive ownership during program download, and `cpu_hold` tells `control` to keep `PcSel = PcWait` until its fetch completes.

## Interface
- `AW`, default 5: program memory address width (32 words).
- `DW`, default 16: instruction word width.
- `MAX_LD_BURST`, default 4: consecutive loader grants allowed while a CPU request is pending.

- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `cpu_req` in 1: fetch request; held until `cpu_ack`.
- `cpu_addr` in `AW`: fetch address; stable while `cpu_req` is high.
- `cpu_ack` out 1: one-cycle pulse; `cpu_rdata` is valid in the same cycle.
- `cpu_rdata` out `DW`: fetched word.
- `cpu_hold` out 1: `cpu_req & ~cpu_ack`; stall indication to `control`.
- `ld_req` in 1: loader request; held until `ld_ack`.
- `ld_we` in 1: 1 = write, 0 = read.
- `ld_addr` in `AW`, `ld_wdata` in `DW`: stable while `ld_req` is high.
- `ld_lock` in 1: loader-exclusive mode.
- `ld_ack` out 1: one-cycle pulse.
- `ld_rdata` out `DW`: read-back word; valid when `ld_ack` is high after a read.
- `mem_en`, `mem_we` out 1; `mem_addr` out `AW`; `mem_wdata` out `DW`: memory port.
- `mem_rdata` in `DW`: memory data; registered output, valid the cycle after `mem_en`.

## Operation
- States:
  - IDLE → ACCESS on any eligible request.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Every transaction takes exactly 3 cycles; there is no pipelining.
- Grant decision, made in IDLE only:
  - If `ld_lock` = 1: the loader is the only eligible requester, and `cpu_req` is ignored.
  - Otherwise, if both requests are high: the loader wins unless `burst_cnt == MAX_LD_BURST`, in which case the CPU wins.
  - Otherwise the sole requester wins.
- On grant, the owner, address, write-enable and write data are registered. The requester's inputs are not sampled again for this transaction.
- ACCESS: `mem_en` = 1, `mem_we` = owner is the loader and the latched `we` is set; `mem_addr` and `mem_wdata` come from the latched values.
- RESP:
  - The owner's ack is 1.
  - `cpu_rdata` / `ld_rdata` = `mem_rdata`.
  - The data outputs are 0 when the corresponding ack is low.
- `burst_cnt` (width clog2(`MAX_LD_BURST`+1)):
  - Increments on each loader grant while `cpu_req` is high.
  - Clears on a CPU grant, or whenever `cpu_req` is low in IDLE.
  - Saturates at `MAX_LD_BURST`.
  - Does not count while `ld_lock` is high.
- A requester that drops `req` before its ack: the transaction still completes and the ack still pulses; the requester discards it.
- `ld_lock` rising mid-transaction has no effect on the in-flight access; it applies at the next IDLE decision.
- Address range is the full `AW`; there is no wrap or bounds logic.

## Timing
- Reset (synchronous, active-high) sets:
  - state = IDLE, `burst_cnt` = 0, latches = 0.
  - All outputs 0, except `cpu_hold`, which follows `cpu_req`.
- Latency: request seen high in IDLE at cycle n gives `mem_en` at n+1 and ack at n+2. The next grant decision is at n+3.
- Maximum throughput is one transaction per 3 cycles.
- Reset asserted during ACCESS: that cycle's memory write is still committed by the RAM at the same edge. State goes to IDLE and no ack is issued.
- Reset asserted during RESP: the ack is still visible in that cycle (it is combinational from state). Next cycle is IDLE.
- Simultaneous requests are resolved in one cycle as specified above; no request is lost.

## Structure
- Add to the shared `opcodes` package:
  - `typedef enum logic [1:0] {ArbIdle, ArbAccess, ArbResp} arb_state_t`
  - `typedef enum logic {OwnCpu, OwnLd} arb_owner_t`
- Sub-module `burst_limiter` holds the saturating fairness counter. It takes inputs `inc`, `clr`, `sat_en` and outputs `at_limit`.
- `control` ORs `cpu_hold` into its PcWait condition.

## Test plan
- CPU fetch only, `cpu_addr` = 5'h03, memory holds 16'hA5C3 → `mem_en` at n+1, `cpu_ack` with `cpu_rdata` = 16'hA5C3 at n+2, `cpu_hold` high for n..n+1.
- Loader writes 16'h1234 to 5'h1F, then reads 5'h1F → `mem_we` = 1 in the first ACCESS; the second `ld_ack` returns `ld_rdata` = 16'h1234.
- Both requests held continuously, `MAX_LD_BURST` = 4, `ld_lock` = 0 → grant order L,L,L,L,C,L,L,L,L,C; 15 cycles to the first `cpu_ack` (CPU granted at cycle 12).
- `ld_lock` = 1 with `cpu_req` held for 20 cycles → no `cpu_ack`, `cpu_hold` stays 1; drop `ld_lock` → CPU is granted at the next IDLE.
- `Reset` asserted in the ACCESS cycle of a loader write of 16'hBEEF to 5'h07 → no `ld_ack`, state IDLE next cycle, and a read of 5'h07 returns 16'hBEEF.
- `cpu_req` withdrawn in the ACCESS cycle → `cpu_ack` still pulses at RESP, `burst_cnt` clears, arbiter returns to IDLE.
